gate_array_cell_bank: RTL and testbench



---
 rtl/gate_array_cell_bank_if.sv | 45 ++++
 rtl/gate_array_cell_bank.sv | 66 ++++++
 tb/tb_gate_array_cell_bank.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gate_array_cell_bank_if.sv
// ---------------------------------------------------------------------------
// gate_array_cell_bank_if
// Purpose : Groups the data and control signals of one gate_array_cell_bank.
//           Clock and reset are not part of the bundle and stay plain ports.
// Signals : ln      counter load, active low
//           ci      counter carry in (count qualifier, also gates co)
//           en      counter enable
//           d       counter parallel load value [CW]
//           q       counter value [CW]
//           co      counter carry out, combinational
//           fde_d   clear-type flop data input
//           fde_q   clear-type flop output
//           fde_qn  clear-type flop inverted output
//           fdn_d   set-type flop data input
//           fdn_q   set-type flop output
//           fdn_qn  set-type flop inverted output
// Modports: master drives the inputs of the bank and observes its outputs;
//           slave is the bank itself.
// ---------------------------------------------------------------------------
interface gate_array_cell_bank_if #(
  parameter int CW = 4
);
  logic          ln;
  logic          ci;
  logic          en;
  logic [CW-1:0] d;
  logic [CW-1:0] q;
  logic          co;
  logic          fde_d;
  logic          fde_q;
  logic          fde_qn;
  logic          fdn_d;
  logic          fdn_q;
  logic          fdn_qn;

  modport master (
    output ln, ci, en, d, fde_d, fdn_d,
    input  q, co, fde_q, fde_qn, fdn_q, fdn_qn
  );

  modport slave (
    input  ln, ci, en, d, fde_d, fdn_d,
    output q, co, fde_q, fde_qn, fdn_q, fdn_qn
  );
endinterface

// File: rtl/gate_array_cell_bank.sv
// ---------------------------------------------------------------------------
// gate_array_cell_bank
// Purpose : Three gate-array primitive cells sharing one clock and one reset:
//           - a CW-bit loadable synchronous up-counter with carry chain (C43),
//           - a D flop that is cleared by reset (FDE),
//           - a D flop that is set by reset (FDN).
//           Banks cascade through co -> ci/en to build wider counters.
// Ports   : ck_i   clock, all state changes on the rising edge
//           cln_i  synchronous active-low reset, sampled on rising ck_i
//           bus    gate_array_cell_bank_if.slave (see interface header)
// ---------------------------------------------------------------------------
module gate_array_cell_bank #(
  parameter int CW = 4
) (
  input logic                  ck_i,
  input logic                  cln_i,
  gate_array_cell_bank_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fde_q, fde_d;
  logic          fdn_q, fdn_d;

  // Load beats count; count needs both ci and en; otherwise hold.
  // Wrap from all-ones to zero falls out of the modulo-2^CW add.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.ln) begin
      cnt_d = bus.d;
    end else if (bus.ci && bus.en) begin
      cnt_d = cnt_q + CW'(1);
    end
    fde_d = bus.fde_d;
    fdn_d = bus.fdn_d;
  end

  // Reset is synchronous and overrides load, count and flop data alike.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge ck_i) begin
    if (!cln_i) begin
      cnt_q <= '0;
      fde_q <= 1'b0;
      fdn_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      fde_q <= fde_d;
      fdn_q <= fdn_d;
    end
  end

  assign bus.q      = cnt_q;
  // Carry out is unregistered so the next bank sees it in the same cycle and
  // advances on the very edge where this bank wraps. It ignores en, ln and
  // reset on purpose: only ci and the terminal count qualify it.
  assign bus.co     = bus.ci & (cnt_q == CNT_MAX);
  assign bus.fde_q  = fde_q;
  assign bus.fde_qn = ~fde_q;
  assign bus.fdn_q  = fdn_q;
  assign bus.fdn_qn = ~fdn_q;

endmodule

// File: tb/tb_gate_array_cell_bank.sv
// ---------------------------------------------------------------------------
// tb_gate_array_cell_bank
// Directed bench for gate_array_cell_bank. bank0 is driven directly; bank1 is
// the upper half of a two-bank cascade (ci/en fed from bank0.co) and has its
// flops wired as toggles (d fed from qn).
// ---------------------------------------------------------------------------
module tb_gate_array_cell_bank;

  localparam int CW = 4;

  logic ck;
  logic cln;
  int   n_cmp;
  int   n_err;

  gate_array_cell_bank_if #(.CW(CW)) bus0 ();
  gate_array_cell_bank_if #(.CW(CW)) bus1 ();

  gate_array_cell_bank #(.CW(CW)) u_bank0 (
    .ck_i  (ck),
    .cln_i (cln),
    .bus   (bus0.slave)
  );

  gate_array_cell_bank #(.CW(CW)) u_bank1 (
    .ck_i  (ck),
    .cln_i (cln),
    .bus   (bus1.slave)
  );

  // Cascade and toggle wiring for the upper bank.
  assign bus1.ci    = bus0.co;
  assign bus1.en    = bus0.co;
  assign bus1.fde_d = bus1.fde_qn;
  assign bus1.fdn_d = bus1.fdn_qn;

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset edge with everything else trying to change state.
    cln        = 1'b0;
    bus0.ln    = 1'b1;
    bus0.ci    = 1'b1;
    bus0.en    = 1'b1;
    bus0.d     = 4'h9;
    bus0.fde_d = 1'b1;
    bus0.fdn_d = 1'b0;
    bus1.ln    = 1'b1;
    bus1.d     = 4'h0;
    tick();
    check("rst_q",       32'(bus0.q),      32'h0);
    check("rst_co",      32'(bus0.co),     32'h0);
    check("rst_fde_q",   32'(bus0.fde_q),  32'h0);
    check("rst_fde_qn",  32'(bus0.fde_qn), 32'h1);
    check("rst_fdn_q",   32'(bus0.fdn_q),  32'h1);
    check("rst_fdn_qn",  32'(bus0.fdn_qn), 32'h0);

    // Free count: 15 edges to terminal count, 16th wraps and carries up.
    cln        = 1'b1;
    bus0.fde_d = 1'b0;
    bus0.fdn_d = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("cnt15_q",     32'(bus0.q),  32'hF);
    check("cnt15_co",    32'(bus0.co), 32'h1);
    check("cnt15_up_q",  32'(bus1.q),  32'h0);
    tick();
    check("wrap_q",      32'(bus0.q),  32'h0);
    check("wrap_co",     32'(bus0.co), 32'h0);
    check("wrap_up_q",   32'(bus1.q),  32'h1);

    // Load 15 while also latching new data into both flops.
    bus0.ln    = 1'b0;
    bus0.d     = 4'hF;
    bus0.fde_d = 1'b1;
    bus0.fdn_d = 1'b0;
    tick();
    check("ld15_q",      32'(bus0.q),      32'hF);
    check("fde_lat_q",   32'(bus0.fde_q),  32'h1);
    check("fde_lat_qn",  32'(bus0.fde_qn), 32'h0);
    check("fdn_lat_q",   32'(bus0.fdn_q),  32'h0);
    check("fdn_lat_qn",  32'(bus0.fdn_qn), 32'h1);

    // Carry out is gated by ci, not by en; en=0 holds the count.
    bus0.ln = 1'b1;
    bus0.ci = 1'b0;
    #1;
    check("co_ci0",      32'(bus0.co), 32'h0);
    bus0.ci = 1'b1;
    bus0.en = 1'b0;
    #1;
    check("co_en0",      32'(bus0.co), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q",    32'(bus0.q),  32'hF);
      check("hold_co",   32'(bus0.co), 32'h1);
    end

    // Load beats count.
    bus0.ln = 1'b0;
    bus0.d  = 4'h5;
    tick();
    check("ld5_q",       32'(bus0.q), 32'h5);
    bus0.d  = 4'b1100;
    bus0.en = 1'b1;
    tick();
    check("ld_vs_cnt_q", 32'(bus0.q), 32'hC);

    // Reset beats load; flop data still opposes reset values.
    cln = 1'b0;
    tick();
    check("rst_ld_q",     32'(bus0.q),     32'h0);
    check("rst_ld_fde",   32'(bus0.fde_q), 32'h0);
    check("rst_ld_fdn",   32'(bus0.fdn_q), 32'h1);
    check("rst_up_fde",   32'(bus1.fde_q), 32'h0);
    check("rst_up_fdn",   32'(bus1.fdn_q), 32'h1);

    // Two-bank cascade from 0x0E; toggle flops step every edge.
    cln     = 1'b1;
    bus0.ln = 1'b0;
    bus0.d  = 4'hE;
    bus1.ln = 1'b0;
    bus1.d  = 4'h0;
    tick();
    check("chain_ld_lo",  32'(bus0.q),     32'hE);
    check("chain_ld_hi",  32'(bus1.q),     32'h0);
    check("tgl1_fde",     32'(bus1.fde_q), 32'h1);
    check("tgl1_fdn",     32'(bus1.fdn_q), 32'h0);
    bus0.ln = 1'b1;
    bus1.ln = 1'b1;
    bus0.ci = 1'b1;
    bus0.en = 1'b1;
    tick();
    check("chain1_lo",    32'(bus0.q),     32'hF);
    check("chain1_hi",    32'(bus1.q),     32'h0);
    check("tgl2_fde",     32'(bus1.fde_q), 32'h0);
    check("tgl2_fdn",     32'(bus1.fdn_q), 32'h1);
    tick();
    check("chain2_lo",    32'(bus0.q),     32'h0);
    check("chain2_hi",    32'(bus1.q),     32'h1);
    check("tgl3_fde",     32'(bus1.fde_q), 32'h1);
    check("tgl3_fdn",     32'(bus1.fdn_q), 32'h0);
    check("tgl3_fde_qn",  32'(bus1.fde_qn), 32'h0);
    check("tgl3_fdn_qn",  32'(bus1.fdn_qn), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
